// File: rtl/pipo_universal.sv
// Parametrised universal register: parallel load, bidirectional shift/rotate,
// clear and invert, with a saturating shift counter that flags a full frame.
module pipo_universal #(
  parameter int unsigned          WIDTH       = 4,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  localparam int unsigned         CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_SHR    = 3'b010,
    MODE_SHL    = 3'b011,
    MODE_ROR    = 3'b100,
    MODE_ROL    = 3'b101,
    MODE_CLEAR  = 3'b110,
    MODE_INVERT = 3'b111
  } mode_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  mode_t            op;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_inc;

  assign op      = mode_t'(mode);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    q_next   = q;
    cnt_next = cnt;
    if (en) begin
      unique case (op)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        MODE_SHR: begin
          q_next   = {sin, q[WIDTH-1:1]};
          cnt_next = cnt_inc;
        end
        MODE_SHL: begin
          q_next   = {q[WIDTH-2:0], sin};
          cnt_next = cnt_inc;
        end
        MODE_ROR: begin
          q_next   = {q[0], q[WIDTH-1:1]};
          cnt_next = cnt_inc;
        end
        MODE_ROL: begin
          q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
          cnt_next = cnt_inc;
        end
        MODE_CLEAR: begin
          q_next   = '0;
          cnt_next = '0;
        end
        MODE_INVERT: q_next = ~q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q   <= RESET_VALUE;
      cnt <= '0;
    end else begin
      q   <= q_next;
      cnt <= cnt_next;
    end
  end

  // sout shows the bit that leaves on the next shift in the selected direction
  assign sout       = mode[0] ? q[WIDTH-1] : q[0];
  assign qb         = ~q;
  assign frame_done = (cnt == CNT_MAX);

endmodule

// File: tb/tb_pipo_universal.sv
// Directed bench for pipo_universal at WIDTH=4, RESET_VALUE=0.
module tb_pipo_universal;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [3:0] d;
  logic       sin;
  logic [3:0] q;
  logic [3:0] qb;
  logic       sout;
  logic [2:0] cnt;
  logic       frame_done;

  int tests = 0;
  int fails = 0;

  pipo_universal #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .qb(qb), .sout(sout), .cnt(cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] val);
    reset = 1'b1; en = 1'b1; mode = 3'b001; d = val;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; mode = 3'b001; d = 4'b1011; sin = 1'b0;
    tick();
    tests++; if (q !== 4'b0000) begin fails++; $display("FAIL reset_q got %b want 0000", q); end
    tests++; if (qb !== 4'b1111) begin fails++; $display("FAIL reset_qb got %b want 1111", qb); end
    tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got %b want 0", frame_done); end
    do_load(4'b1011);
    tests++; if (q !== 4'b1011) begin fails++; $display("FAIL load_q got %b want 1011", q); end
    tests++; if (qb !== 4'b0100) begin fails++; $display("FAIL load_qb got %b want 0100", qb); end
    tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL load_cnt got %0d want 0", cnt); end
  endtask

  task automatic test_shift_right();
    logic [3:0] exp_q [5] = '{4'b1101, 4'b1110, 4'b1111, 4'b1111, 4'b1111};
    logic       exp_s [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] exp_c [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       exp_f [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_load(4'b1011);
    mode = 3'b010; sin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (sout !== exp_s[i]) begin fails++; $display("FAIL shr_sout[%0d] got %b want %b", i, sout, exp_s[i]); end
      tick();
      tests++; if (q !== exp_q[i]) begin fails++; $display("FAIL shr_q[%0d] got %b want %b", i, q, exp_q[i]); end
      tests++; if (cnt !== exp_c[i]) begin fails++; $display("FAIL shr_cnt[%0d] got %0d want %0d", i, cnt, exp_c[i]); end
      tests++; if (frame_done !== exp_f[i]) begin fails++; $display("FAIL shr_fd[%0d] got %b want %b", i, frame_done, exp_f[i]); end
    end
  endtask

  task automatic test_rotate_left();
    logic [3:0] exp_q [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    logic       exp_s [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_load(4'b1001);
    mode = 3'b101; sin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (sout !== exp_s[i]) begin fails++; $display("FAIL rol_sout[%0d] got %b want %b", i, sout, exp_s[i]); end
      tick();
      tests++; if (q !== exp_q[i]) begin fails++; $display("FAIL rol_q[%0d] got %b want %b", i, q, exp_q[i]); end
    end
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL rol_fd got %b want 1", frame_done); end
  endtask

  task automatic test_mixed_direction();
    do_load(4'b0001);
    mode = 3'b100;
    tick();
    tests++; if (q !== 4'b1000) begin fails++; $display("FAIL ror_q got %b want 1000", q); end
    mode = 3'b011; sin = 1'b1;
    tick();
    tests++; if (q !== 4'b0001) begin fails++; $display("FAIL shl_q got %b want 0001", q); end
    tests++; if (cnt !== 3'd2) begin fails++; $display("FAIL mixed_cnt got %0d want 2", cnt); end
  endtask

  task automatic test_enable_invert();
    do_load(4'b1011);
    en = 1'b0; mode = 3'b001; d = 4'b0101;
    tick();
    tests++; if (q !== 4'b1011) begin fails++; $display("FAIL en0_q got %b want 1011", q); end
    en = 1'b1; mode = 3'b111;
    tick();
    tests++; if (q !== 4'b0100) begin fails++; $display("FAIL inv_q got %b want 0100", q); end
    tests++; if (qb !== 4'b1011) begin fails++; $display("FAIL inv_qb got %b want 1011", qb); end
    tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL inv_cnt got %0d want 0", cnt); end
    mode = 3'b000;
    tick();
    tests++; if (q !== 4'b0100) begin fails++; $display("FAIL hold_q got %b want 0100", q); end
  endtask

  task automatic test_reset_mid_frame();
    for (int r = 0; r < 2; r++) begin
      do_load(4'b0110);
      mode = 3'b010; sin = 1'b1;
      tick(); tick();
      tests++; if (cnt !== 3'd2) begin fails++; $display("FAIL mid_pre_cnt[%0d] got %0d want 2", r, cnt); end
      reset = 1'b0; en = (r == 0); mode = 3'b010;
      tick();
      tests++; if (q !== 4'b0000) begin fails++; $display("FAIL mid_q[%0d] got %b want 0000", r, q); end
      tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL mid_cnt[%0d] got %0d want 0", r, cnt); end
      reset = 1'b1; en = 1'b1;
    end
  endtask

  task automatic test_clear_reload();
    do_load(4'b1010);
    mode = 3'b100;
    repeat (4) tick();
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL clr_pre_fd got %b want 1", frame_done); end
    mode = 3'b110;
    tick();
    tests++; if (q !== 4'b0000) begin fails++; $display("FAIL clr_q got %b want 0000", q); end
    tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL clr_cnt got %0d want 0", cnt); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL clr_fd got %b want 0", frame_done); end
    do_load(4'b1111);
    mode = 3'b011; sin = 1'b0;
    #1;
    tests++; if (sout !== 1'b1) begin fails++; $display("FAIL shl_sout got %b want 1", sout); end
    tick();
    tests++; if (q !== 4'b1110) begin fails++; $display("FAIL reload_shl_q got %b want 1110", q); end
    tests++; if (cnt !== 3'd1) begin fails++; $display("FAIL reload_cnt got %0d want 1", cnt); end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 3'b000; d = 4'b0000; sin = 1'b0;
    #2;
    test_reset();
    test_shift_right();
    test_rotate_left();
    test_mixed_direction();
    test_enable_invert();
    test_reset_mid_frame();
    test_clear_reload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipo_universal.md
# pipo_universal

Parametrised successor to the team's fixed 4-bit parallel-in/parallel-out register. It holds a WIDTH-bit word and supports parallel load, serial shift in both directions, rotate, clear and invert. It also counts shift/rotate operations to flag when a full serial frame has moved through. It sits between parallel datapath logic and bit-serial links, and replaces the fixed-width PIPO wherever serial access or width scaling is needed.

## Interface
- WIDTH, 4, register width in bits; legal range is WIDTH ≥ 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.
- CW, $clog2(WIDTH+1), width of cnt (derived localparam, not overridable).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled only at posedge clk.
- en  in  1  operation enable; 0 = hold all state.
- mode  in  3  operation select (see Operation).
- d  in  WIDTH  parallel load data.
- sin  in  1  serial input bit.
- q  out  WIDTH  register contents.
- qb  out  WIDTH  bitwise complement of q, i.e. ~q.
- sout  out  1  serial output bit; combinational from mode and q.
- cnt  out  CW  shift/rotate count since the last load or clear; saturates at WIDTH.
- frame_done  out  1  high exactly when cnt == WIDTH.

## Operation
- Priority at each posedge: reset == 0 first, then en == 0 (hold), then mode.
- Reset (reset == 0): q ← RESET_VALUE and cnt ← 0. This applies regardless of en and mode.
- mode encoding, applied when en == 1:
  - 000 hold: q and cnt unchanged.
  - 001 load: q ← d, cnt ← 0.
  - 010 shift right: q ← {sin, q[WIDTH-1:1]}.
  - 011 shift left: q ← {q[WIDTH-2:0], sin}.
  - 100 rotate right: q ← {q[0], q[WIDTH-1:1]}.
  - 101 rotate left: q ← {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 clear: q ← 0, cnt ← 0.
  - 111 invert: q ← ~q, cnt unchanged.
- Counter:
  - Modes 010–101 increment cnt by 1, saturating at WIDTH.
  - Changing direction mid-frame does not reset cnt.
- sout:
  - q[0] when mode[0] == 0.
  - q[WIDTH-1] when mode[0] == 1.
  - sout therefore shows the bit about to leave on the next shift in the selected direction.
- qb is always ~q, full width. No separate state is kept for qb.
- frame_done is decoded from registered cnt (cnt == WIDTH). It is a level, not a pulse, and it stays high through further shifts until a load, clear or reset.

## Timing
- Latency: one cycle. q, qb, cnt and frame_done reflect an operation immediately after the edge that samples it.
- sout is combinational. It changes within the same cycle when mode or q changes, with no register stage.
- Reset values: q = RESET_VALUE, qb = ~RESET_VALUE, cnt = 0, frame_done = 0, sout per mode from RESET_VALUE.
- Reset asserted mid-frame takes effect at the next edge and discards any operation requested in that cycle.
- Saturation boundary: with cnt == WIDTH, a further shift still moves data, and cnt stays at WIDTH.
- Undefined d or sin is not masked. X on sin propagates into q only in shift modes.

## Test plan
1. Reset with WIDTH=4, RESET_VALUE=0:
   - Hold reset=0, en=1, mode=001, d=1011 for one edge -> q=0000, qb=1111, cnt=0, frame_done=0.
   - Release reset and load 1011 -> q=1011, qb=0100, cnt=0.
2. Shift right from q=1011 with sin=1, mode=010, four edges:
   - sout before each edge = 1, 1, 0, 1.
   - q = 1101, 1110, 1111, 1111.
   - cnt = 1..4; frame_done=1 after the 4th edge.
   - A 5th edge keeps cnt=4.
3. Rotate left from loaded 1001, mode=101:
   - q = 0011, 0110, 1100, 1001.
   - frame_done=1 after the 4th edge; sout (= q[3]) before the edges = 1, 0, 0, 1.
4. Enable and invert:
   - en=0, mode=001, d=0101 -> q stays 1011.
   - en=1, mode=111 -> q=0100, qb=1011, cnt unchanged.
   - mode=000 -> no change.
5. Reset mid-frame:
   - After two shifts (cnt=2), drive reset=0 with en=1, mode=010 -> q=0000, cnt=0.
   - Repeat with en=0 -> same result.
6. Clear and reload:
   - From frame_done=1, mode=110 -> q=0000, cnt=0, frame_done=0.
   - Load 1111 then shift left with sin=0 -> q=1110, sout (= q[3]) before the edge = 1.
